// File: rtl/sigmoid_sampler.sv
// sigmoid_sampler
// Stochastic neuron activation stage. The signed fixed-point local field is
// registered (S1), mapped to a firing probability with a clamped
// piecewise-linear sigmoid p = 0.5 + x/8 (S2), and then sampled into a binary
// spin by comparing p with a 16-bit Galois LFSR (S3). The three stages move
// together under a single enable, so a stalled consumer freezes the whole pipe.
//
// Build option: define SIGMOID_SAMPLER_DETERMINISTIC_EN to replace the LFSR
// with the constant 16'h8000, giving a hard threshold at field >= 0 for
// bring-up. The LFSR is not built in that configuration.
//
// FRAC_BITS + 3 must be at least 16 so that the sigmoid shift is non-negative.
module sigmoid_sampler #(
    parameter int          PRECISION_BITS = 32,
    parameter int          FRAC_BITS      = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          RBM_CLOCK_FREQ = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRECISION_BITS-1:0] field_in,
    input  logic                      field_valid,
    output logic                      field_ready,
    output logic                      spin_out,
    output logic [15:0]               prob_out,
    output logic                      spin_valid,
    input  logic                      spin_ready
);

    // Right shift that turns a field with FRAC_BITS fractional bits into x/8
    // expressed in Q0.16.
    localparam int SHIFT = FRAC_BITS + 3 - 16;

    // 0.5 in Q0.16, widened to the signed intermediate width.
    localparam logic signed [PRECISION_BITS:0] P_HALF =
        {{(PRECISION_BITS-16){1'b0}}, 17'h08000};

    // Clamped sigmoid: p = (field >>> SHIFT) + 0.5, saturated to [0, 0xFFFF].
    function automatic logic [15:0] sigmoid_pwl(input logic [PRECISION_BITS-1:0] f);
        logic signed [PRECISION_BITS:0] t;
        logic signed [PRECISION_BITS:0] p;
        logic [15:0]                    res;
        t = $signed({f[PRECISION_BITS-1], f}) >>> SHIFT;
        p = t + P_HALF;
        if (p[PRECISION_BITS]) begin
            res = 16'h0000;
        end else if (|p[PRECISION_BITS-1:16]) begin
            res = 16'hFFFF;
        end else begin
            res = p[15:0];
        end
        return res;
    endfunction

    logic                      w_en;
    logic [15:0]               w_p_next;
    logic [15:0]               w_threshold;
    logic                      w_spin_next;

    logic                      r_s1_valid;
    logic [PRECISION_BITS-1:0] r_s1_field;
    logic                      r_s2_valid;
    logic [15:0]               r_s2_p;
    logic                      r_s3_valid;
    logic                      r_s3_spin;
    logic [15:0]               r_s3_prob;

    // Configuration values that only document the build; kept visible here so
    // they are not reported as dangling.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{LFSR_SEED, RBM_CLOCK_FREQ};

    // Pipeline enable: advance when the output slot is empty or being drained.
    always_comb begin
        w_en        = 1'b0;
        field_ready = 1'b0;
        w_en        = !r_s3_valid || spin_ready;
        field_ready = w_en && !rst;
    end

    // Sigmoid of the field currently held in S1.
    always_comb begin
        w_p_next = 16'h0000;
        w_p_next = sigmoid_pwl(r_s1_field);
    end

    // Spin decision: fire when the random threshold does not exceed p.
    always_comb begin
        w_spin_next = 1'b0;
        if (w_threshold <= r_s2_p) begin
            w_spin_next = 1'b1;
        end else begin
            w_spin_next = 1'b0;
        end
    end

`ifdef SIGMOID_SAMPLER_DETERMINISTIC_EN
    // Fixed mid-scale threshold: spin is 1 exactly when field >= 0.
    always_comb begin
        w_threshold = 16'h8000;
    end
`else
    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Galois step for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ 16'hB400;
        end else begin
            n = n;
        end
        return n;
    endfunction

    logic [15:0] r_lfsr;
    logic        w_lfsr_step;

    // The LFSR moves only when a valid sample leaves S2, so each real sample
    // consumes exactly one random value and bubbles/stalls consume none.
    always_comb begin
        w_lfsr_step = 1'b0;
        w_lfsr_step = w_en && r_s2_valid;
    end

    // LFSR state; reloads the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_INIT;
        end else if (w_lfsr_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // The comparison uses the pre-step LFSR value of this cycle.
    always_comb begin
        w_threshold = 16'h0000;
        w_threshold = r_lfsr;
    end
`endif

    // Three-stage pipeline; bubbles travel with the data, everything holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_field <= '0;
            r_s2_valid <= 1'b0;
            r_s2_p     <= 16'h0000;
            r_s3_valid <= 1'b0;
            r_s3_spin  <= 1'b0;
            r_s3_prob  <= 16'h0000;
        end else if (w_en) begin
            r_s1_valid <= field_valid;
            r_s1_field <= field_in;
            r_s2_valid <= r_s1_valid;
            r_s2_p     <= w_p_next;
            r_s3_valid <= r_s2_valid;
            r_s3_spin  <= w_spin_next;
            r_s3_prob  <= r_s2_p;
        end
    end

    assign spin_out   = r_s3_spin;
    assign prob_out   = r_s3_prob;
    assign spin_valid = r_s3_valid;

endmodule

// File: tb/tb_sigmoid_sampler.sv
// tb_sigmoid_sampler
// Directed and randomized stimulus for sigmoid_sampler. Accepted fields are
// queued; each output handshake is compared with a reference computed from
// the field by plain arithmetic (floor(x/8) + 0.5, clamped) and with a model
// LFSR that advances once per delivered sample since the last reset.
module tb_sigmoid_sampler;

    logic        clk;
    logic        rst;
    logic [31:0] field_in;
    logic        field_valid;
    logic        field_ready;
    logic        spin_out;
    logic [15:0] prob_out;
    logic        spin_valid;
    logic        spin_ready;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] m_lfsr = 16'hACE1;
    int          out_cnt = 0;
    int          ones_cnt = 0;
    bit          hold_pending = 1'b0;
    logic        held_spin;
    logic [15:0] held_prob;
    bit          saw_stall = 1'b0;
    logic        last_spin = 1'b0;
    logic [15:0] last_prob = 16'h0000;
    bit          obs_sv;
    bit          acc;

    sigmoid_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .field_in    (field_in),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .spin_out    (spin_out),
        .prob_out    (prob_out),
        .spin_valid  (spin_valid),
        .spin_ready  (spin_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Probability for a Q15.16 field: 0.5 + x/8, floor rounding, clamped.
    function automatic logic [15:0] ref_p(input logic [31:0] f);
        longint x;
        longint t;
        longint p;
        x = longint'($signed(f));
        if (x >= 0) t = x / 8;
        else        t = -((-x + 7) / 8);
        p = t + 32768;
        if (p < 0)          return 16'h0000;
        else if (p > 65535) return 16'hFFFF;
        else                return p[15:0];
    endfunction

    // Next LFSR value, taps 0xB400, written arithmetically.
    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
        int v;
        v = int'(s);
        if (v % 2 == 1) return 16'((v / 2) ^ 32'h0000B400);
        else            return 16'(v / 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, observe 1 ns later,
    // then advance past the next rising edge to the following falling edge.
    task automatic step(input bit r, input bit fv, input logic [31:0] f, input bit sr);
        logic [31:0] ef;
        logic [15:0] ep;
        logic        es;
        rst         = r;
        field_valid = fv;
        field_in    = f;
        spin_ready  = sr;
        acc         = 1'b0;
        #1;
        obs_sv = spin_valid;
        if (r) begin
            check("ready_in_reset", 32'(field_ready), 32'd0);
            exp_q.delete();
            m_lfsr       = 16'hACE1;
            hold_pending = 1'b0;
        end else begin
            check("field_ready", 32'(field_ready), 32'(!spin_valid || sr));
            if (hold_pending) begin
                check("hold_valid", 32'(spin_valid), 32'd1);
                check("hold_spin", 32'(spin_out), 32'(held_spin));
                check("hold_prob", 32'(prob_out), 32'(held_prob));
            end
            if (spin_valid && sr) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 32'(spin_valid), 32'd0);
                end else begin
                    ef = exp_q.pop_front();
                    ep = ref_p(ef);
`ifdef SIGMOID_SAMPLER_DETERMINISTIC_EN
                    es = (ep >= 16'h8000);
`else
                    es = (m_lfsr <= ep);
`endif
                    m_lfsr = ref_lfsr_next(m_lfsr);
                    check("prob_out", 32'(prob_out), 32'(ep));
                    check("spin_out", 32'(spin_out), 32'(es));
                    out_cnt++;
                    ones_cnt += int'(spin_out);
                    last_spin = spin_out;
                    last_prob = prob_out;
                end
            end
            hold_pending = spin_valid && !sr;
            held_spin    = spin_out;
            held_prob    = prob_out;
            acc          = fv && field_ready;
            if (acc) exp_q.push_back(f);
            if (fv && !field_ready) saw_stall = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, f, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || spin_valid); i++)
            step(1'b0, 1'b0, 32'h0, 1'b1);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          o;
        int          n;
        int          lat;
        int          cyc;
        int          idx;
        logic [31:0] f;
        logic [31:0] fields[8];
        bit          fv;
        bit          sr;

        rst         = 1'b1;
        field_valid = 1'b0;
        field_in    = 32'h0;
        spin_ready  = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_spin_valid", 32'(spin_valid), 32'd0);
        check("rst_spin_out", 32'(spin_out), 32'd0);
        check("rst_prob_out", 32'(prob_out), 32'd0);

        // Latency of a single zero field
        step(1'b0, 1'b1, 32'h00000000, 1'b1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_sv && lat == 0) lat = k;
        end
        check("latency", 32'(lat), 32'd3);
        check("zero_prob", 32'(last_prob), 32'h8000);
`ifdef SIGMOID_SAMPLER_DETERMINISTIC_EN
        check("zero_spin", 32'(last_spin), 32'd1);
`else
        check("zero_spin", 32'(last_spin), 32'd0);
`endif

        // Saturation at +4.0 and -4.0
        o = out_cnt; n = ones_cnt;
        feed(32'h00040000, 200);
        drain("drain_pos4");
        check("pos4_count", 32'(out_cnt - o), 32'd200);
        check("pos4_ones", 32'(ones_cnt - n), 32'd200);
        check("pos4_prob", 32'(last_prob), 32'hFFFF);
        o = out_cnt; n = ones_cnt;
        feed(32'hFFFC0000, 200);
        drain("drain_neg4");
        check("neg4_count", 32'(out_cnt - o), 32'd200);
        check("neg4_ones", 32'(ones_cnt - n), 32'd0);
        check("neg4_prob", 32'(last_prob), 32'h0000);

        // +1.0 from a fresh seed: p = 0.625
        step(1'b1, 1'b0, 32'h0, 1'b0);
        o = out_cnt; n = ones_cnt;
        feed(32'h00010000, 4096);
        drain("drain_pos1");
        check("pos1_count", 32'(out_cnt - o), 32'd4096);
        check("pos1_prob", 32'(last_prob), 32'hA000);
`ifdef SIGMOID_SAMPLER_DETERMINISTIC_EN
        check("pos1_ones", 32'(ones_cnt - n), 32'd4096);
`else
        check("pos1_ones_in_range", 32'((ones_cnt - n) >= 2400 && (ones_cnt - n) <= 2720), 32'd1);
`endif

        // Stream of 8 distinct fields with the consumer stalled for 5 cycles
        for (int i = 0; i < 8; i++) fields[i] = 32'hFFFF0000 + 32'(i) * 32'h00004000;
        saw_stall = 1'b0;
        o = out_cnt;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 100) begin
            sr = !(cyc >= 4 && cyc < 9);
            step(1'b0, 1'b1, fields[idx], sr);
            if (acc) idx++;
            cyc++;
        end
        check("stream_all_accepted", 32'(idx), 32'd8);
        drain("drain_stream");
        check("stream_saw_stall", 32'(saw_stall), 32'd1);
        check("stream_count", 32'(out_cnt - o), 32'd8);

        // Randomized traffic with random backpressure
        o = out_cnt;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            fv = ($urandom_range(0, 3) != 0);
            sr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) f = 32'($urandom_range(0, 1048575)) - 32'h00080000;
            else                           f = $urandom;
            step(1'b0, fv, f, sr);
            if (acc) n++;
        end
        drain("drain_random");
        check("random_count", 32'(out_cnt - o), 32'(n));

        // Reset with three samples in flight
        step(1'b0, 1'b1, 32'h00020000, 1'b1);
        step(1'b0, 1'b1, 32'hFFFE0000, 1'b1);
        step(1'b0, 1'b1, 32'h00008000, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("flush_valid", 32'(spin_valid), 32'd0);
        o = out_cnt; n = ones_cnt;
        step(1'b0, 1'b1, 32'h00018000, 1'b1);
        drain("drain_after_rst");
        check("after_rst_count", 32'(out_cnt - o), 32'd1);
        check("after_rst_prob", 32'(last_prob), 32'hB000);
        check("after_rst_spin", 32'(ones_cnt - n), 32'd1);

`ifdef SIGMOID_SAMPLER_DETERMINISTIC_EN
        // Hard threshold around zero
        step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        drain("drain_det_neg");
        check("det_neg_prob", 32'(last_prob), 32'h7FFF);
        check("det_neg_spin", 32'(last_spin), 32'd0);
        step(1'b0, 1'b1, 32'h00000000, 1'b1);
        drain("drain_det_zero");
        check("det_zero_spin", 32'(last_spin), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sigmoid_sampler.md
Name: sigmoid_sampler

Overview:
Stochastic neuron activation stage that sits directly downstream of adder_tree. It takes the signed fixed-point local field (the weighted sum) and maps it to a firing probability with a saturating piecewise-linear sigmoid. It then samples a binary spin by comparing that probability against an internal LFSR random number. The result is a 1-bit spin plus its probability, delivered on a valid/ready handshake to the RBM node-update logic.

Parameters:
PRECISION_BITS, 32, width of field_in (two's complement fixed point; must match adder_tree).
FRAC_BITS, 16, fractional bits of field_in; must satisfy FRAC_BITS + 3 >= 16.
LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
RBM_CLOCK_FREQ, 50_000_000, machine clock in Hz; informational only, unused in logic.

Ports:
clk  input  1  machine clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
field_in  input  PRECISION_BITS  signed local field from adder_tree.result.
field_valid  input  1  field_in is valid this cycle.
field_ready  output  1  stage accepts field_in this cycle.
spin_out  output  1  sampled spin (1 = on).
prob_out  output  16  firing probability in Q0.16, unsigned.
spin_valid  output  1  spin_out and prob_out are valid.
spin_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Three-stage pipeline: S1 registers field, S2 computes p, S3 samples the spin. Each stage has its own valid bit.
- Pipeline enable: en = !s3_valid || spin_ready. All stages advance together when en=1; when en=0 every stage holds.
- field_ready = en && !rst. A transfer occurs when field_valid && field_ready.
- Bubbles (valid=0) propagate like data; there is no compaction.
- Latency: 3 cycles from the accepting edge to spin_valid with spin_ready held high. Throughput is 1 sample per clock.
- S2 arithmetic: shift = FRAC_BITS + 3 - 16. t = (field >>> shift), arithmetic shift, sign-extended to PRECISION_BITS+1. Then p = t + 16'h8000.
- Saturation: if p < 0, p = 16'h0000; if p > 16'hFFFF, p = 16'hFFFF. This gives p = 0.5 + x/8 clamped; the linear range is -4.0 <= x < 4.0.
- LFSR: 16-bit Galois, polynomial 0xB400 (x^16+x^14+x^13+x^11+1).
  - Reset value is LFSR_SEED.
  - Steps once on every cycle where en=1 and S2 holds a valid sample; holds otherwise.
  - Never reaches 0.
- S3 sampling: spin = (lfsr <= p), using the lfsr value before that cycle's step. prob_out = p.
  - p = 16'hFFFF: always 1.
  - p = 16'h0000: always 0, since the LFSR is never 0.
- Output stability: spin_out, prob_out and spin_valid stay stable while spin_valid=1 and spin_ready=0.
- Reset (synchronous, any time, including mid-stream):
  - All stage valid bits, spin_valid, spin_out and prob_out clear to 0.
  - LFSR reloads its seed.
  - In-flight samples are discarded.
  - field_ready = 0 during the reset cycle.
- Simultaneous output handshake and new input (spin_valid && spin_ready && field_valid): both transfers complete in the same cycle with no bubble inserted.

Optional Feature:
SIGMOID_SAMPLER_DETERMINISTIC_EN.
- Defined: the comparison uses the constant 16'h8000 in place of the LFSR, so spin = (16'h8000 <= p), a hard threshold at field >= 0. The LFSR logic is removed. Used for debug and bring-up.
- Undefined: stochastic sampling as described above.

Test Plan:
- Reset, then field_in=0x00000000 valid for 1 cycle with spin_ready=1 -> spin_valid rises exactly 3 cycles later; prob_out=0x8000; spin_out = (0xACE1 <= 0x8000) = 0.
- field_in=0x00040000 (+4.0), 200 consecutive samples -> prob_out=0xFFFF and spin_out=1 on every sample. field_in=0xFFFC0000 (-4.0) -> prob_out=0x0000 and spin_out=0 on every sample.
- field_in=0x00010000 (+1.0), 4096 samples -> prob_out=0xA000; count of spin_out=1 within 2400..2720 (p=0.625).
- Stream of 8 distinct fields with spin_ready low for 5 cycles mid-stream -> field_ready falls after the pipeline fills; outputs hold stable; all 8 results arrive in order with none lost or duplicated.
- Assert rst for one cycle while 3 samples are in flight -> spin_valid=0 next cycle; the next sample's spin is compared against the seed 0xACE1, matching a fresh start.
- With SIGMOID_SAMPLER_DETERMINISTIC_EN: field=0xFFFFFFFF -> spin 0 (p=0x7FFF); field=0x00000000 -> spin 1.
